// File: rtl/i2c_txn_sequencer_if.sv
// Host request/response and byte-level I2C master strobes for i2c_txn_sequencer.
// The master modport is the sequencer's view; the slave modport is the host/master-side view.
interface i2c_txn_sequencer_if;
  logic       req_valid;
  logic       req_rnw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic       rsp_done;
  logic [1:0] rsp_status;
  logic [7:0] rsp_rdata;
  logic [2:0] i2c_cmd;
  logic [7:0] i2c_din;
  logic       i2c_wr;
  logic       i2c_ready;
  logic       i2c_done;
  logic       i2c_ack;
  logic [7:0] i2c_dout;

  modport master (
    input  req_valid, req_rnw, req_dev, req_reg, req_wdata,
    output req_ready, rsp_done, rsp_status, rsp_rdata,
    output i2c_cmd, i2c_din, i2c_wr,
    input  i2c_ready, i2c_done, i2c_ack, i2c_dout
  );

  modport slave (
    output req_valid, req_rnw, req_dev, req_reg, req_wdata,
    input  req_ready, rsp_done, rsp_status, rsp_rdata,
    input  i2c_cmd, i2c_din, i2c_wr,
    output i2c_ready, i2c_done, i2c_ack, i2c_dout
  );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// Walks one I2C register write/read through the byte-level master's command strobes.
// Define I2C_SEQ_NACK_ABORT_EN to skip to the final STOP after a NACKed write byte.
module i2c_txn_sequencer #(
  parameter int TO_W   = 16,
  parameter int TO_CYC = 50000
) (
  input logic            clk,
  input logic            rst,
  i2c_txn_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, WAIT_DONE, NEXT, FINISH} state_t;

  localparam logic [2:0] C_START   = 3'b000;
  localparam logic [2:0] C_WR      = 3'b001;
  localparam logic [2:0] C_RD      = 3'b010;
  localparam logic [2:0] C_STOP    = 3'b011;
  localparam logic [2:0] C_RESTART = 3'b100;
  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_NACK   = 2'b01;
  localparam logic [1:0] ST_TO     = 2'b10;

  state_t          state;
  logic            rnw;
  logic [6:0]      dev;
  logic [7:0]      rg;
  logic [7:0]      wd;
  logic [2:0]      step;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      st;
  logic [7:0]      shadow;
  logic [2:0]      last;
  logic [10:0]     nxt;
  logic            to_hit;

  // {cmd, din} for step s of the write (5-step) or read (7-step) list
  function automatic logic [10:0] step_op(input logic r, input logic [2:0] s,
                                          input logic [6:0] d, input logic [7:0] a,
                                          input logic [7:0] w);
    step_op = {C_STOP, 8'h00};
    case (s)
      3'd0:    step_op = {C_START, 8'h00};
      3'd1:    step_op = {C_WR, d, 1'b0};
      3'd2:    step_op = {C_WR, a};
      3'd3:    step_op = r ? {C_RESTART, 8'h00} : {C_WR, w};
      3'd4:    step_op = r ? {C_WR, d, 1'b1} : {C_STOP, 8'h00};
      3'd5:    step_op = {C_RD, 8'h00};
      default: step_op = {C_STOP, 8'h00};
    endcase
  endfunction

  assign last   = rnw ? 3'd6 : 3'd4;
  assign nxt    = step_op(rnw, step + 3'd1, dev, rg, wd);
  assign to_hit = (to_cnt == TO_W'(TO_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.rsp_done   <= 1'b0;
      bus.rsp_status <= ST_OK;
      bus.rsp_rdata  <= 8'h00;
      bus.i2c_cmd    <= C_STOP;
      bus.i2c_din    <= 8'h00;
      bus.i2c_wr     <= 1'b0;
      rnw            <= 1'b0;
      dev            <= 7'h00;
      rg             <= 8'h00;
      wd             <= 8'h00;
      step           <= 3'd0;
      to_cnt         <= '0;
      st             <= ST_OK;
      shadow         <= 8'h00;
    end else begin
      bus.i2c_wr   <= 1'b0;
      bus.rsp_done <= 1'b0;
      if (state inside {ISSUE, WAIT_LO, WAIT_HI, WAIT_DONE}) to_cnt <= to_cnt + 1'b1;
      case (state)
        IDLE: if (bus.req_valid) begin
          rnw           <= bus.req_rnw;
          dev           <= bus.req_dev;
          rg            <= bus.req_reg;
          wd            <= bus.req_wdata;
          step          <= 3'd0;
          st            <= ST_OK;
          to_cnt        <= '0;
          bus.i2c_cmd   <= C_START;
          bus.i2c_din   <= 8'h00;
          bus.req_ready <= 1'b0;
          state         <= ISSUE;
        end
        ISSUE:
          if (bus.i2c_ready) begin
            bus.i2c_wr <= 1'b1;
            state      <= (bus.i2c_cmd == C_WR || bus.i2c_cmd == C_RD) ? WAIT_DONE : WAIT_LO;
          end else if (to_hit) begin
            st    <= ST_TO;
            state <= FINISH;
          end
        WAIT_LO:
          if (!bus.i2c_ready) state <= WAIT_HI;
          else if (to_hit) begin
            st    <= ST_TO;
            state <= FINISH;
          end
        WAIT_HI:
          if (bus.i2c_ready) state <= NEXT;
          else if (to_hit) begin
            st    <= ST_TO;
            state <= FINISH;
          end
        // completion takes priority over a same-cycle timeout
        WAIT_DONE:
          if (bus.i2c_done) begin
            if (bus.i2c_cmd == C_WR && bus.i2c_ack) begin
              st <= ST_NACK;
`ifdef I2C_SEQ_NACK_ABORT_EN
              step <= last - 3'd1;
`endif
            end
            if (bus.i2c_cmd == C_RD) shadow <= bus.i2c_dout;
            state <= NEXT;
          end else if (to_hit) begin
            st    <= ST_TO;
            state <= FINISH;
          end
        NEXT:
          if (step == last) state <= FINISH;
          else begin
            step                       <= step + 3'd1;
            {bus.i2c_cmd, bus.i2c_din} <= nxt;
            to_cnt                     <= '0;
            state                      <= ISSUE;
          end
        FINISH: begin
          bus.rsp_done   <= 1'b1;
          bus.rsp_status <= st;
          if (rnw && st == ST_OK) bus.rsp_rdata <= shadow;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a behavioural byte-level master/slave model.
module tb_i2c_txn_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_txn_sequencer_if bus();
  i2c_txn_sequencer #(.TO_W(16), .TO_CYC(100)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int nchk = 0;
  int nerr = 0;

  // master model controls, set by the stimulus process
  int         nack_idx = -1;
  logic       no_done  = 1'b0;
  logic [7:0] rd_byte  = 8'h00;

  // model state and logs, owned by the model process
  int         busy = 0;
  logic [2:0] cur = 3'b011;
  int         cur_idx = 0;
  int         wr_cnt = 0;
  int         cyc_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         acc_cnt = 0;
  logic [2:0] cmd_q[$];
  logic [7:0] din_q[$];
  int         wcyc_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // e packs expected commands, step 0 in the low 3 bits
  task automatic check_cmds(input string tag, input int q0, input int n, input logic [20:0] e);
    check({tag, "_n"}, cmd_q.size() - q0, n);
    for (int i = 0; i < n && q0 + i < cmd_q.size(); i++)
      check(tag, {29'd0, cmd_q[q0+i]}, {29'd0, e[i*3 +: 3]});
  endtask

  // Master: busy 3 cycles per command; WR/RD end with done_tick (unless no_done), others just re-raise ready
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.i2c_ready <= 1'b1;
      bus.i2c_done  <= 1'b0;
      bus.i2c_ack   <= 1'b0;
      bus.i2c_dout  <= 8'h00;
      busy = 0;
    end else begin
      cyc_cnt++;
      bus.i2c_done <= 1'b0;
      if (bus.req_valid && bus.req_ready) acc_cnt++;
      if (bus.rsp_done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
      if (bus.i2c_wr) begin
        cmd_q.push_back(bus.i2c_cmd);
        din_q.push_back(bus.i2c_din);
        wcyc_q.push_back(cyc_cnt);
        cur = bus.i2c_cmd;
        if (cur == 3'b000) wr_cnt = 0;
        if (cur == 3'b001) begin
          cur_idx = wr_cnt;
          wr_cnt++;
        end
        bus.i2c_ready <= 1'b0;
        busy = 3;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          if (cur == 3'b001 || cur == 3'b010) begin
            if (!no_done) begin
              bus.i2c_done  <= 1'b1;
              bus.i2c_ack   <= (cur == 3'b001 && cur_idx == nack_idx);
              bus.i2c_dout  <= rd_byte;
              bus.i2c_ready <= 1'b1;
            end
          end else bus.i2c_ready <= 1'b1;
        end
      end
    end
  end

  task automatic run_txn(input logic r, input logic [6:0] d, input logic [7:0] a, input logic [7:0] w);
    int n = 0;
    bus.req_rnw   = r;
    bus.req_dev   = d;
    bus.req_reg   = a;
    bus.req_wdata = w;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (!bus.rsp_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_seen", {31'd0, bus.rsp_done}, 1);
  endtask

  initial begin
    int q0, d0, a0, seen, n;
    bus.req_valid = 1'b0;
    bus.req_rnw   = 1'b0;
    bus.req_dev   = 7'h00;
    bus.req_reg   = 8'h00;
    bus.req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready",  {31'd0, bus.req_ready}, 1);
    check("rst_done",   {31'd0, bus.rsp_done}, 0);
    check("rst_status", {30'd0, bus.rsp_status}, 0);
    check("rst_rdata",  {24'd0, bus.rsp_rdata}, 0);
    check("rst_cmd",    {29'd0, bus.i2c_cmd}, 3);
    check("rst_din",    {24'd0, bus.i2c_din}, 0);
    check("rst_wr",     {31'd0, bus.i2c_wr}, 0);
    rst = 1'b1;
    @(negedge clk);

    // plain write, all ACKed
    q0 = cmd_q.size(); d0 = done_cnt;
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5);
    check("wr_status", {30'd0, bus.rsp_status}, 0);
    repeat (2) @(negedge clk);
    check("wr_done_cnt", done_cnt - d0, 1);
    check_cmds("wr_cmd", q0, 5, {3'd3, 3'd1, 3'd1, 3'd1, 3'd0});
    if (cmd_q.size() >= q0 + 4) begin
      check("wr_din1", {24'd0, din_q[q0+1]}, 32'hA0);
      check("wr_din2", {24'd0, din_q[q0+2]}, 32'h10);
      check("wr_din3", {24'd0, din_q[q0+3]}, 32'hA5);
    end
    check("wr_status_held", {30'd0, bus.rsp_status}, 0);

    // plain read
    q0 = cmd_q.size(); rd_byte = 8'h3C;
    run_txn(1'b1, 7'h50, 8'h20, 8'h00);
    check("rd_status", {30'd0, bus.rsp_status}, 0);
    check("rd_rdata",  {24'd0, bus.rsp_rdata}, 32'h3C);
    repeat (2) @(negedge clk);
    check_cmds("rd_cmd", q0, 7, {3'd3, 3'd2, 3'd1, 3'd4, 3'd1, 3'd1, 3'd0});
    if (cmd_q.size() >= q0 + 5) begin
      check("rd_din1", {24'd0, din_q[q0+1]}, 32'hA0);
      check("rd_din2", {24'd0, din_q[q0+2]}, 32'h20);
      check("rd_din4", {24'd0, din_q[q0+4]}, 32'hA1);
    end

    // write NACKed on the address byte
    q0 = cmd_q.size(); nack_idx = 0;
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5);
    check("nkw_status", {30'd0, bus.rsp_status}, 1);
    check("nkw_rdata",  {24'd0, bus.rsp_rdata}, 32'h3C);
    repeat (2) @(negedge clk);
`ifdef I2C_SEQ_NACK_ABORT_EN
    check_cmds("nkw_cmd", q0, 3, {3'd3, 3'd1, 3'd0});
`else
    check_cmds("nkw_cmd", q0, 5, {3'd3, 3'd1, 3'd1, 3'd1, 3'd0});
`endif

    // read NACKed on the read-address byte: rdata must not update
    q0 = cmd_q.size(); nack_idx = 2; rd_byte = 8'h99;
    run_txn(1'b1, 7'h50, 8'h20, 8'h00);
    check("nkr_status", {30'd0, bus.rsp_status}, 1);
    check("nkr_rdata",  {24'd0, bus.rsp_rdata}, 32'h3C);
    repeat (2) @(negedge clk);
`ifdef I2C_SEQ_NACK_ABORT_EN
    check_cmds("nkr_cmd", q0, 6, {3'd3, 3'd1, 3'd4, 3'd1, 3'd1, 3'd0});
`else
    check_cmds("nkr_cmd", q0, 7, {3'd3, 3'd2, 3'd1, 3'd4, 3'd1, 3'd1, 3'd0});
`endif

    // req_valid held high: two back-to-back transactions, one per accept
    nack_idx = -1;
    q0 = cmd_q.size(); d0 = done_cnt; a0 = acc_cnt; seen = 0; n = 0;
    bus.req_rnw = 1'b0; bus.req_dev = 7'h50; bus.req_reg = 8'h11; bus.req_wdata = 8'h5A;
    bus.req_valid = 1'b1;
    @(negedge clk);
    check("hold_busy_ready", {31'd0, bus.req_ready}, 0);
    while (seen < 2 && n < 4000) begin
      @(negedge clk);
      n++;
      if (bus.rsp_done) seen++;
    end
    bus.req_valid = 1'b0;
    check("hold_seen", seen, 2);
    repeat (4) @(negedge clk);
    check("hold_accepts", acc_cnt - a0, 2);
    check("hold_dones",   done_cnt - d0, 2);
    check("hold_ncmd",    cmd_q.size() - q0, 10);
    check("hold_idle",    {31'd0, bus.req_ready}, 1);

    // master never returns done_tick on the address byte
    q0 = cmd_q.size(); no_done = 1'b1;
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5);
    check("to_status", {30'd0, bus.rsp_status}, 2);
    @(negedge clk);
    check_cmds("to_cmd", q0, 2, {3'd1, 3'd0});
    if (wcyc_q.size() > 0) check("to_latency", done_cyc - wcyc_q[wcyc_q.size()-1], 100);

    // recover the stuck master, then reset mid-transaction
    no_done = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.req_rnw = 1'b0; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", {31'd0, bus.req_ready}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_wr",    {31'd0, bus.i2c_wr}, 0);
    check("post_rst_cmd",   {29'd0, bus.i2c_cmd}, 3);
    check("post_rst_ready", {31'd0, bus.req_ready}, 1);

    q0 = cmd_q.size();
    run_txn(1'b0, 7'h21, 8'h02, 8'h7E);
    check("post_rst_status", {30'd0, bus.rsp_status}, 0);
    repeat (2) @(negedge clk);
    check_cmds("post_rst_cmd", q0, 5, {3'd3, 3'd1, 3'd1, 3'd1, 3'd0});
    if (cmd_q.size() >= q0 + 2) check("post_rst_din1", {24'd0, din_q[q0+1]}, 32'h42);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
